basic_switch: RTL and testbench
===============================

BASIC_SWITCH -- requirements
Module: basic_switch

Interface
REQ-001 Parameter WIDTH, default 65; bit width of each data port; legal range 1..1024.
REQ-002 Parameter PIPE_STAGES, default 1; number of output register stages when the REQ-018 macro is defined; legal range 1..4; ignored otherwise.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in0  input  WIDTH  data input port 0.
REQ-006 in1  input  WIDTH  data input port 1.
REQ-007 out0  output  WIDTH  data output port 0.
REQ-008 out1  output  WIDTH  data output port 1.
REQ-009 control  input  1  route select: 0 = straight, 1 = cross.

Function
REQ-010 Straight routing: control=0 SHALL give out0=in0 and out1=in1.
REQ-011 Cross routing: control=1 SHALL give out0=in1 and out1=in0.
REQ-012 The block SHALL pass all WIDTH bits unmodified, with no masking, no reordering and no interpretation of any bit (bit 0 used as a valid flag by parents is plain data here).
REQ-013 Both outputs SHALL always be driven from exactly one distinct input each; duplication or dropping of an input SHALL be impossible for any control value.
REQ-014 With the REQ-018 macro undefined: routing SHALL be purely combinational (zero latency); clk and rst_n SHALL be unused; outputs SHALL settle within the same cycle inputs change.
REQ-015 With the REQ-018 macro defined: in0, in1 and control SHALL be sampled together on the same edge; outputs SHALL reflect them exactly PIPE_STAGES rising edges later.
REQ-016 Registered mode: when control changes on a cycle, the new routing SHALL apply to that cycle's sampled data only, with no glitch or mixing of old and new routing on any output word.
REQ-017 Registered mode: throughput SHALL be one word pair per cycle with no stalls and no backpressure.

Configuration
REQ-018 Macro BASIC_SWITCH_OUTREG_EN: defined means the PIPE_STAGES-deep output register pipeline per REQ-015..017 is compiled in; undefined means combinational routing per REQ-014 and no flops are inferred.

Reset
REQ-019 Registered mode: rst_n=0 SHALL asynchronously clear every pipeline stage, so out0 and out1 read all-zero immediately, independent of clk.
REQ-020 On rst_n rising, capture SHALL resume at the first rising clk edge at which rst_n is high.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight words; no pre-reset data SHALL appear after release.
REQ-022 Combinational mode: rst_n SHALL have no effect on outputs.

Structure
REQ-023 The block SHALL be a single leaf module with no sub-modules.
REQ-024 No shared package is required; the route-select encodings ROUTE_STRAIGHT=0 and ROUTE_CROSS=1 SHALL be localparams in the module.
REQ-025 The module SHALL be instantiable positionally in the order (in0, in1, out0, out1, control) with clk and rst_n connected by name, so multistage networks can chain it directly.

Verification
REQ-026 Combinational mode: WIDTH=65, in0=0x1_0000_0000_0000_00AA, in1=0x0_0000_0000_0000_0055, control=0 -> out0=in0 and out1=in1 in the same cycle; control=1 -> out0=0x55 and out1=0x1_...AA.
REQ-027 Registered mode, PIPE_STAGES=1: drive pairs (1,2) c=0 then (3,4) c=1 then (5,6) c=0 on consecutive cycles -> outputs one cycle later are (1,2), (4,3), (5,6).
REQ-028 Registered mode, PIPE_STAGES=4: a single pair (0xDEAD,0xBEEF) with c=1 followed by zeros -> out0=0xBEEF and out1=0xDEAD exactly 4 edges later, with zeros before and after.
REQ-029 Registered mode: assert rst_n=0 between clock edges while the pipeline is full -> outputs become 0 before the next edge; after release, the first non-zero output is the first post-release input pair.
REQ-030 Random test: 10000 cycles of random in0, in1 and control in both modes -> a scoreboard swap model matches every output word, and each cycle's outputs are a permutation of that cycle's inputs.

Source files
------------

// File: rtl/basic_switch.sv
// 2x2 crossbar switch: straight or cross routing of two data words.
// Optional output pipeline compiled in with BASIC_SWITCH_OUTREG_EN.
module basic_switch #(
  parameter int WIDTH       = 65,
  parameter int PIPE_STAGES = 1
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  input  logic             control,
  input  logic             clk,
  input  logic             rst_n
);

  localparam logic ROUTE_STRAIGHT = 1'b0;
  localparam logic ROUTE_CROSS    = 1'b1;

  logic [WIDTH-1:0] route0;
  logic [WIDTH-1:0] route1;

  // Select straight or crossed pairing; each output takes one input.
  always_comb begin
    route0 = in0;
    route1 = in1;
    unique case (1'b1)
      (control == ROUTE_CROSS): begin
        route0 = in1;
        route1 = in0;
      end
      (control == ROUTE_STRAIGHT): begin
        route0 = in0;
        route1 = in1;
      end
      default: begin
        route0 = in0;
        route1 = in1;
      end
    endcase
  end

`ifdef BASIC_SWITCH_OUTREG_EN

  logic [WIDTH-1:0] o0_q [PIPE_STAGES];
  logic [WIDTH-1:0] o0_d [PIPE_STAGES];
  logic [WIDTH-1:0] o1_q [PIPE_STAGES];
  logic [WIDTH-1:0] o1_d [PIPE_STAGES];

  // Routed pair enters stage 0; later stages shift one per edge.
  always_comb begin
    o0_d[0] = route0;
    o1_d[0] = route1;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      o0_d[i] = o0_q[i-1];
      o1_d[i] = o1_q[i-1];
    end
  end

  // Pipeline registers; reset flushes every in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        o0_q[i] <= '0;
        o1_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        o0_q[i] <= o0_d[i];
        o1_q[i] <= o1_d[i];
      end
    end
  end

  assign out0 = o0_q[PIPE_STAGES-1];
  assign out1 = o1_q[PIPE_STAGES-1];

`else

  assign out0 = route0;
  assign out1 = route1;

  // Clock and reset have no role in the purely combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

`endif

endmodule

// File: tb/tb_basic_switch.sv
// Self-checking bench for basic_switch.
// Covers both builds, selected by BASIC_SWITCH_OUTREG_EN.
module tb_basic_switch;

  localparam int W = 65;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic         control = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  function automatic logic [2*W-1:0] swap_model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    return c ? {b, a} : {a, b};
  endfunction

`ifdef BASIC_SWITCH_OUTREG_EN

  logic [W-1:0] a0, a1, b0, b1;

  basic_switch #(.WIDTH(W), .PIPE_STAGES(1)) u_p1 (
    .in0(in0), .in1(in1), .out0(a0), .out1(a1),
    .control(control), .clk(clk), .rst_n(rst_n)
  );

  basic_switch #(.WIDTH(W), .PIPE_STAGES(4)) u_p4 (
    .in0(in0), .in1(in1), .out0(b0), .out1(b1),
    .control(control), .clk(clk), .rst_n(rst_n)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    in0 = 65'h1234;
    in1 = 65'h5678;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({a0, a1, b0, b1} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got %h %h %h %h want 0",
               a0, a1, b0, b1);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [W-1:0] v0 [3];
    logic [W-1:0] v1 [3];
    logic         vc [3];
    logic [W-1:0] e0 [3];
    logic [W-1:0] e1 [3];
    v0 = '{65'd1, 65'd3, 65'd5};
    v1 = '{65'd2, 65'd4, 65'd6};
    vc = '{1'b0, 1'b1, 1'b0};
    e0 = '{65'd1, 65'd4, 65'd5};
    e1 = '{65'd2, 65'd3, 65'd6};
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in0 = v0[i];
      in1 = v1[i];
      control = vc[i];
      @(posedge clk);
      #1;
      n_chk++;
      if (a0 !== e0[i] || a1 !== e1[i]) begin
        n_fail++;
        $display("FAIL seq_p1[%0d] got %h %h want %h %h",
                 i, a0, a1, e0[i], e1[i]);
      end
    end
  endtask

  task automatic test_deep();
    logic [W-1:0] x0, x1;
    in0 = '0;
    in1 = '0;
    control = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    in0 = 65'hDEAD;
    in1 = 65'hBEEF;
    control = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk);
      #1;
      in0 = '0;
      in1 = '0;
      control = 1'b0;
      x0 = (j == 4) ? 65'hBEEF : '0;
      x1 = (j == 4) ? 65'hDEAD : '0;
      n_chk++;
      if (b0 !== x0 || b1 !== x1) begin
        n_fail++;
        $display("FAIL deep_p4[edge %0d] got %h %h want %h %h",
                 j, b0, b1, x0, x1);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] x0, x1;
    for (int i = 0; i < 5; i++) begin
      in0 = W'(i + 65'h10);
      in1 = W'(i + 65'h100);
      control = i[0];
      @(posedge clk);
      #1;
    end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a0, a1, b0, b1} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got %h %h %h %h want 0",
               a0, a1, b0, b1);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({a0, a1, b0, b1} !== '0) begin
      n_fail++;
      $display("FAIL held_reset got %h %h %h %h want 0",
               a0, a1, b0, b1);
    end
    in0 = 65'h11;
    in1 = 65'h22;
    control = 1'b0;
    #3 rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (a0 !== 65'h11 || a1 !== 65'h22) begin
        n_fail++;
        $display("FAIL post_reset_p1[%0d] got %h %h want 11 22",
                 j, a0, a1);
      end
      x0 = (j == 4) ? 65'h11 : '0;
      x1 = (j == 4) ? 65'h22 : '0;
      n_chk++;
      if (b0 !== x0 || b1 !== x1) begin
        n_fail++;
        $display("FAIL post_reset_p4[%0d] got %h %h want %h %h",
                 j, b0, b1, x0, x1);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] h0 [4];
    logic [W-1:0] h1 [4];
    logic         hc [4];
    logic [2*W-1:0] e;
    logic ok;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      h0[k] = '0;
      h1[k] = '0;
      hc[k] = 1'b0;
    end
    for (int i = 0; i < 10000; i++) begin
      in0 = rnd();
      in1 = rnd();
      control = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      for (int k = 3; k > 0; k--) begin
        h0[k] = h0[k-1];
        h1[k] = h1[k-1];
        hc[k] = hc[k-1];
      end
      h0[0] = in0;
      h1[0] = in1;
      hc[0] = control;
      e = swap_model(h0[0], h1[0], hc[0]);
      n_chk++;
      if ({a0, a1} !== e) begin
        n_fail++;
        $display("FAIL rand_p1[%0d] got %h %h want %h %h",
                 i, a0, a1, e[2*W-1:W], e[W-1:0]);
      end
      ok = (a0 === h0[0] && a1 === h1[0]) ||
           (a0 === h1[0] && a1 === h0[0]);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL perm_p1[%0d] got %h %h from %h %h",
                 i, a0, a1, h0[0], h1[0]);
      end
      e = swap_model(h0[3], h1[3], hc[3]);
      n_chk++;
      if ({b0, b1} !== e) begin
        n_fail++;
        $display("FAIL rand_p4[%0d] got %h %h want %h %h",
                 i, b0, b1, e[2*W-1:W], e[W-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_deep();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

`else

  logic [W-1:0] out0, out1;

  basic_switch #(.WIDTH(W)) u_dut (
    .in0(in0), .in1(in1), .out0(out0), .out1(out1),
    .control(control), .clk(clk), .rst_n(rst_n)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    in0 = 65'h1_0000_0000_0000_0001;
    in1 = 65'h0_8000_0000_0000_0000;
    control = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (out0 !== 65'h0_8000_0000_0000_0000 ||
        out1 !== 65'h1_0000_0000_0000_0001) begin
      n_fail++;
      $display("FAIL reset_ignored got %h %h want %h %h",
               out0, out1, in1, in0);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (out0 !== 65'h0_8000_0000_0000_0000 ||
        out1 !== 65'h1_0000_0000_0000_0001) begin
      n_fail++;
      $display("FAIL reset_release got %h %h want %h %h",
               out0, out1, in1, in0);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] v0 [4];
    logic [W-1:0] v1 [4];
    v0 = '{65'h1_0000_0000_0000_00AA, {W{1'b1}},
           65'h0_0000_0000_0000_0001, 65'h1_5555_5555_5555_5555};
    v1 = '{65'h0_0000_0000_0000_0055, 65'h0,
           65'h1_0000_0000_0000_0000, 65'h0_AAAA_AAAA_AAAA_AAAA};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in0 = v0[i];
      in1 = v1[i];
      control = 1'b0;
      #1;
      n_chk++;
      if (out0 !== v0[i] || out1 !== v1[i]) begin
        n_fail++;
        $display("FAIL straight[%0d] got %h %h want %h %h",
                 i, out0, out1, v0[i], v1[i]);
      end
      control = 1'b1;
      #1;
      n_chk++;
      if (out0 !== v1[i] || out1 !== v0[i]) begin
        n_fail++;
        $display("FAIL cross[%0d] got %h %h want %h %h",
                 i, out0, out1, v1[i], v0[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] e;
    logic ok;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in0 = rnd();
      in1 = rnd();
      control = 1'($urandom_range(1));
      if ((i % 7) == 3) rst_n = ~rst_n;
      #1;
      e = swap_model(in0, in1, control);
      n_chk++;
      if ({out0, out1} !== e) begin
        n_fail++;
        $display("FAIL rand[%0d] got %h %h want %h %h",
                 i, out0, out1, e[2*W-1:W], e[W-1:0]);
      end
      ok = (out0 === in0 && out1 === in1) ||
           (out0 === in1 && out1 === in0);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL perm[%0d] got %h %h from %h %h",
                 i, out0, out1, in0, in1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

`endif

endmodule
